// File: rtl/data_memory_lsu.sv
// RV32I load/store unit with an integrated word-organised data memory.
// Loads are combinational; stores commit on the clock edge; the first faulting access is latched.
module data_memory_lsu #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic        fault_clear,
  output logic [31:0] rdata,
  output logic        access_err,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic        fault_is_store
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [AW-1:0] idx_s;
  logic [31:0]   word_s;
  logic [31:0]   shifted_s;
  logic          illegal_s;
  logic          misaligned_s;
  logic [3:0]    be_s;
  logic [31:0]   wd_s;
  logic          unused_addr_s;

  assign idx_s         = addr[AW+1:2];
  assign word_s        = mem_r[idx_s];
  assign shifted_s     = word_s >> {addr[1:0], 3'b000};
  assign unused_addr_s = ^addr[31:AW+2];

  // Legality and alignment; store rules take precedence when mem_write is high.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (mem_write) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
        default:                illegal_s = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
        default:                illegal_s = 1'b0;
      endcase
    end
    case (funct3[1:0])
      2'b01:   misaligned_s = addr[0];
      2'b10:   misaligned_s = (addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    access_err = (mem_read | mem_write) & (illegal_s | misaligned_s);
  end

  // Load data extraction with sign or zero extension.
  always_comb begin
    rdata = 32'h0000_0000;
    if (mem_read && !access_err) begin
      case (funct3)
        3'b000:  rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
        3'b001:  rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
        3'b010:  rdata = word_s;
        3'b100:  rdata = {24'h00_0000, shifted_s[7:0]};
        3'b101:  rdata = {16'h0000, shifted_s[15:0]};
        default: rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_s = 4'b0000;
    wd_s = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_s = 4'b0001 << addr[1:0];
        wd_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_s = addr[1] ? 4'b1100 : 4'b0011;
        wd_s = {2{wdata[15:0]}};
      end
      2'b10:   be_s = 4'b1111;
      default: be_s = 4'b0000;
    endcase
    if (!mem_write || access_err) begin
      be_s = 4'b0000;
    end else begin
      be_s = be_s;
    end
  end

  // Memory array: cleared on reset, byte-lane writes otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= wd_s[8*b +: 8];
        end
      end
    end
  end

  // Sticky fault capture; a new fault coinciding with a clear wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid    <= 1'b0;
      fault_addr     <= 32'h0000_0000;
      fault_is_store <= 1'b0;
    end else if (access_err && (!fault_valid || fault_clear)) begin
      fault_valid    <= 1'b1;
      fault_addr     <= addr;
      fault_is_store <= mem_write;
    end else if (fault_clear) begin
      fault_valid    <= 1'b0;
    end else begin
      fault_valid    <= fault_valid;
    end
  end
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: stimulus queues expectations, a negedge monitor checks them.
module tb_data_memory_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        fault_clear = 1'b0;
  logic [31:0] rdata;
  logic        access_err;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        fault_is_store;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  data_memory_lsu #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .fault_clear(fault_clear), .rdata(rdata), .access_err(access_err),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_is_store(fault_is_store)
  );

  always #5 clk = ~clk;

  // Monitor: mid-cycle, compare every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        item_t it;
        logic [31:0] act;
        it = q.pop_front();
        case (it.sel)
          0:       act = rdata;
          1:       act = {31'h0, access_err};
          2:       act = {31'h0, fault_valid};
          3:       act = fault_addr;
          default: act = {31'h0, fault_is_store};
        endcase
        n_cmp++;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input int sel, input logic [31:0] e);
    item_t it;
    it.name = nm;
    it.sel  = sel;
    it.exp  = e;
    q.push_back(it);
  endtask

  task automatic push_fault(input string nm, input logic v, input logic [31:0] a, input logic s);
    push({nm, ".fault_valid"}, 2, {31'h0, v});
    push({nm, ".fault_addr"}, 3, a);
    push({nm, ".fault_is_store"}, 4, {31'h0, s});
  endtask

  task automatic op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    push({nm, ".rdata"}, 0, exp_rd);
    push({nm, ".access_err"}, 1, {31'h0, exp_err});
    cyc();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    fault_clear = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Preload, create a fault, then reset mid-store.
    op("pre_sw0",  1'b0, 1'b1, 3'b010, 32'h0,  32'hA5A5_A5A5, 32'h0, 1'b0);
    op("pre_sw4",  1'b0, 1'b1, 3'b010, 32'h4,  32'h0000_0001, 32'h0, 1'b0);
    op("pre_swfc", 1'b0, 1'b1, 3'b010, 32'hFC, 32'hFFFF_0000, 32'h0, 1'b0);
    op("pre_lw4",  1'b1, 1'b0, 3'b010, 32'h4,  32'h0, 32'h0000_0001, 1'b0);
    op("pre_mis",  1'b0, 1'b1, 3'b010, 32'h2,  32'h0, 32'h0, 1'b1);
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h8; wdata = 32'h7777_7777;
    #2 rst = 1'b1;
    cyc();
    mem_write = 1'b0;
    cyc();
    rst = 1'b0;
    push_fault("rst", 1'b0, 32'h0, 1'b0);
    op("rst_lw0",  1'b1, 1'b0, 3'b010, 32'h0,  32'h0, 32'h0, 1'b0);
    op("rst_lw4",  1'b1, 1'b0, 3'b010, 32'h4,  32'h0, 32'h0, 1'b0);
    op("rst_lwfc", 1'b1, 1'b0, 3'b010, 32'hFC, 32'h0, 32'h0, 1'b0);
    op("rst_lw8",  1'b1, 1'b0, 3'b010, 32'h8,  32'h0, 32'h0, 1'b0);

    // Sign and zero extension.
    op("sw10",  1'b0, 1'b1, 3'b010, 32'h10, 32'h8000_80FF, 32'h0, 1'b0);
    op("lb10",  1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0);
    op("lbu10", 1'b1, 1'b0, 3'b100, 32'h10, 32'h0, 32'h0000_00FF, 1'b0);
    op("lh12",  1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0);
    op("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 1'b0);

    // Partial-lane stores; upper wdata bits must not leak into other lanes.
    op("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    op("sb21", 1'b0, 1'b1, 3'b000, 32'h21, 32'h1234_56AA, 32'h0, 1'b0);
    op("sh22", 1'b0, 1'b1, 3'b001, 32'h22, 32'hCAFE_BEEF, 32'h0, 1'b0);
    op("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA44, 1'b0);

    // Misaligned store suppressed and captured; later fault ignored.
    op("sw24",  1'b0, 1'b1, 3'b010, 32'h24, 32'hDEAD_BEEF, 32'h0, 1'b0);
    push_fault("pre_fault", 1'b0, 32'h0, 1'b0);
    op("sw26",  1'b0, 1'b1, 3'b010, 32'h26, 32'h0000_0001, 32'h0, 1'b1);
    push_fault("fault1", 1'b1, 32'h26, 1'b1);
    op("lw24",  1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'hDEAD_BEEF, 1'b0);
    op("lh31",  1'b1, 1'b0, 3'b001, 32'h31, 32'h0, 32'h0, 1'b1);
    push_fault("held", 1'b1, 32'h26, 1'b1);
    op("idle1", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);

    // Clear with coincident fault recaptures; clear alone drops the flag.
    fault_clear = 1'b1;
    op("lw3",   1'b1, 1'b0, 3'b010, 32'h3, 32'h0, 32'h0, 1'b1);
    push_fault("recap", 1'b1, 32'h3, 1'b0);
    op("idle2", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    fault_clear = 1'b1;
    op("clr",   1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    push("cleared.fault_valid", 2, 32'h0);
    op("idle3", 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);

    // Address wrap, illegal encodings, read-during-write.
    op("sw104",  1'b0, 1'b1, 3'b010, 32'h104, 32'h1234_5678, 32'h0, 1'b0);
    op("lw4w",   1'b1, 1'b0, 3'b010, 32'h4,   32'h0, 32'h1234_5678, 1'b0);
    op("ld011",  1'b1, 1'b0, 3'b011, 32'h8,   32'h0, 32'h0, 1'b1);
    op("ld110",  1'b1, 1'b0, 3'b110, 32'h4,   32'h0, 32'h0, 1'b1);
    op("rw4",    1'b1, 1'b1, 3'b010, 32'h4,   32'h0000_0055, 32'h1234_5678, 1'b0);
    op("lw4rw",  1'b1, 1'b0, 3'b010, 32'h4,   32'h0, 32'h0000_0055, 1'b0);
    op("st011",  1'b0, 1'b1, 3'b011, 32'h4,   32'hFFFF_FFFF, 32'h0, 1'b1);
    op("rw100",  1'b1, 1'b1, 3'b100, 32'h4,   32'hFFFF_FFFF, 32'h0, 1'b1);
    op("lw4ill", 1'b1, 1'b0, 3'b010, 32'h4,   32'h0, 32'h0000_0055, 1'b0);
    op("lbu7",   1'b1, 1'b0, 3'b100, 32'h7,   32'h0, 32'h0000_0000, 1'b0);

    repeat (2) cyc();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
